// File: rtl/trap_ctrl_pkg.sv
// rtl/trap_ctrl_pkg.sv - CSR addresses, mstatus bit positions and FSM states for trap_ctrl
package trap_ctrl_pkg;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        W_MEPC    = 3'd1,
        W_MCAUSE  = 3'd2,
        W_MSTAT   = 3'd3,
        RET_MSTAT = 3'd4,
        REDIR     = 3'd5
    } trap_state_t;

endpackage

// File: rtl/trap_mstatus_upd.sv
// rtl/trap_mstatus_upd.sv - next-mstatus value for trap entry (ret_mode=0) or mret (ret_mode=1)
module trap_mstatus_upd
    import trap_ctrl_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            ret_mode,
    input  logic [XLEN-1:0] mstatus_in,
    output logic [XLEN-1:0] mstatus_out
);

    always_comb begin
        mstatus_out = mstatus_in;
        if (ret_mode) begin
            mstatus_out[MSTATUS_MIE]  = mstatus_in[MSTATUS_MPIE];
            mstatus_out[MSTATUS_MPIE] = 1'b1;
        end else begin
            mstatus_out[MSTATUS_MPIE] = mstatus_in[MSTATUS_MIE];
            mstatus_out[MSTATUS_MIE]  = 1'b0;
        end
        // Only machine mode exists, so MPP is pinned to M on both paths
        if (XLEN >= 13)
            mstatus_out[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    end

endmodule

// File: rtl/trap_ctrl.sv
// rtl/trap_ctrl.sv - machine-mode trap entry / mret sequencer owning the CSR write port
// Optional: TRAP_VECTORED_EN enables vectored interrupt targets from mtvec MODE=1.
module trap_ctrl
    import trap_ctrl_pkg::*;
#(
    parameter int XLEN   = 64,
    parameter int CSR_AW = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              trap_valid,
    input  logic [XLEN-1:0]   trap_cause,
    input  logic [XLEN-1:0]   trap_pc,
    input  logic              mret_valid,
    output logic              trap_ack,
    input  logic              pipe_csr_we,
    input  logic [CSR_AW-1:0] pipe_csr_idx,
    input  logic [XLEN-1:0]   pipe_csr_wdata,
    input  logic [XLEN-1:0]   csr_mtvec,
    input  logic [XLEN-1:0]   csr_mepc,
    input  logic [XLEN-1:0]   csr_mstatus,
    output logic              csr_we,
    output logic [CSR_AW-1:0] csr_idx,
    output logic [XLEN-1:0]   csr_wdata,
    output logic              stall,
    output logic              flush,
    output logic              redirect_valid,
    output logic [XLEN-1:0]   redirect_pc
);

    trap_state_t       state, state_nxt;
    logic [XLEN-1:0]   cap_pc, cap_cause;
    logic [XLEN-1:0]   target, target_nxt;
    logic [XLEN-1:0]   mstatus_new;
    logic [XLEN-1:0]   mtvec_base, entry_target;

    logic              we_c, stall_c, flush_c, redir_c, ack_c;
    logic [CSR_AW-1:0] idx_c;
    logic [XLEN-1:0]   wdata_c, rpc_c;

    trap_mstatus_upd #(.XLEN(XLEN)) u_mstatus_upd (
        .ret_mode    (state == RET_MSTAT),
        .mstatus_in  (csr_mstatus),
        .mstatus_out (mstatus_new)
    );

    assign mtvec_base = {csr_mtvec[XLEN-1:2], 2'b00};

`ifdef TRAP_VECTORED_EN
    // Vector offset 4*cause; the shift drops the top cause bits so the sum wraps mod 2^XLEN
    always_comb begin
        entry_target = mtvec_base;
        if (csr_mtvec[1:0] == 2'b01 && cap_cause[XLEN-1])
            entry_target = mtvec_base + {cap_cause[XLEN-3:0], 2'b00};
    end
`else
    logic unused_mtvec_mode;
    assign unused_mtvec_mode = ^csr_mtvec[1:0];
    assign entry_target      = mtvec_base;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cap_pc    <= '0;
            cap_cause <= '0;
            target    <= '0;
        end else begin
            state  <= state_nxt;
            target <= target_nxt;
            if (state == IDLE && trap_valid) begin
                cap_pc    <= trap_pc;
                cap_cause <= trap_cause;
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        target_nxt = target;
        we_c       = 1'b0;
        idx_c      = '0;
        wdata_c    = '0;
        stall_c    = 1'b1;
        flush_c    = 1'b0;
        redir_c    = 1'b0;
        ack_c      = 1'b0;
        rpc_c      = '0;
        case (state)
            IDLE: begin
                stall_c = 1'b0;
                we_c    = pipe_csr_we;
                idx_c   = pipe_csr_idx;
                wdata_c = pipe_csr_wdata;
                if (trap_valid)
                    state_nxt = W_MEPC;
                else if (mret_valid)
                    state_nxt = RET_MSTAT;
            end
            W_MEPC: begin
                we_c      = 1'b1;
                idx_c     = CSR_AW'(CSR_MEPC);
                wdata_c   = cap_pc;
                state_nxt = W_MCAUSE;
            end
            W_MCAUSE: begin
                we_c      = 1'b1;
                idx_c     = CSR_AW'(CSR_MCAUSE);
                wdata_c   = cap_cause;
                state_nxt = W_MSTAT;
            end
            W_MSTAT: begin
                we_c       = 1'b1;
                idx_c      = CSR_AW'(CSR_MSTATUS);
                wdata_c    = mstatus_new;
                target_nxt = entry_target;
                state_nxt  = REDIR;
            end
            RET_MSTAT: begin
                we_c       = 1'b1;
                idx_c      = CSR_AW'(CSR_MSTATUS);
                wdata_c    = mstatus_new;
                target_nxt = csr_mepc;
                state_nxt  = REDIR;
            end
            REDIR: begin
                stall_c   = 1'b0;
                flush_c   = 1'b1;
                redir_c   = 1'b1;
                ack_c     = 1'b1;
                rpc_c     = target;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Reset forces every output low immediately, including the IDLE pass-through
    assign csr_we         = we_c & ~rst;
    assign csr_idx        = rst ? '0 : idx_c;
    assign csr_wdata      = rst ? '0 : wdata_c;
    assign stall          = stall_c & ~rst;
    assign flush          = flush_c & ~rst;
    assign redirect_valid = redir_c & ~rst;
    assign redirect_pc    = rst ? '0 : rpc_c;
    assign trap_ack       = ack_c & ~rst;

endmodule

// File: tb/tb_trap_ctrl.sv
// tb/tb_trap_ctrl.sv - directed self-checking bench for trap_ctrl
module tb_trap_ctrl;

    localparam int XLEN   = 64;
    localparam int CSR_AW = 12;

    logic              clk = 1'b0;
    logic              rst;
    logic              trap_valid, mret_valid;
    logic [XLEN-1:0]   trap_cause, trap_pc;
    logic              trap_ack;
    logic              pipe_csr_we;
    logic [CSR_AW-1:0] pipe_csr_idx;
    logic [XLEN-1:0]   pipe_csr_wdata;
    logic [XLEN-1:0]   csr_mtvec, csr_mepc, csr_mstatus;
    logic              csr_we;
    logic [CSR_AW-1:0] csr_idx;
    logic [XLEN-1:0]   csr_wdata;
    logic              stall, flush, redirect_valid;
    logic [XLEN-1:0]   redirect_pc;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    trap_ctrl #(.XLEN(XLEN), .CSR_AW(CSR_AW)) dut (
        .clk            (clk),
        .rst            (rst),
        .trap_valid     (trap_valid),
        .trap_cause     (trap_cause),
        .trap_pc        (trap_pc),
        .mret_valid     (mret_valid),
        .trap_ack       (trap_ack),
        .pipe_csr_we    (pipe_csr_we),
        .pipe_csr_idx   (pipe_csr_idx),
        .pipe_csr_wdata (pipe_csr_wdata),
        .csr_mtvec      (csr_mtvec),
        .csr_mepc       (csr_mepc),
        .csr_mstatus    (csr_mstatus),
        .csr_we         (csr_we),
        .csr_idx        (csr_idx),
        .csr_wdata      (csr_wdata),
        .stall          (stall),
        .flush          (flush),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_csr(input string tag, input logic we, input logic [CSR_AW-1:0] idx,
                             input logic [XLEN-1:0] wd, input logic stl);
        check({tag, ".csr_we"},    XLEN'(csr_we), XLEN'(we));
        check({tag, ".csr_idx"},   XLEN'(csr_idx), XLEN'(idx));
        check({tag, ".csr_wdata"}, csr_wdata, wd);
        check({tag, ".stall"},     XLEN'(stall), XLEN'(stl));
        check({tag, ".redir"},     XLEN'(redirect_valid), '0);
    endtask

    task automatic check_redir(input string tag, input logic [XLEN-1:0] pc);
        check({tag, ".redirect_valid"}, XLEN'(redirect_valid), 1);
        check({tag, ".redirect_pc"},    redirect_pc, pc);
        check({tag, ".trap_ack"},       XLEN'(trap_ack), 1);
        check({tag, ".flush"},          XLEN'(flush), 1);
        check({tag, ".stall"},          XLEN'(stall), 0);
        check({tag, ".csr_we"},         XLEN'(csr_we), 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".csr_we"},         XLEN'(csr_we), 0);
        check({tag, ".csr_idx"},        XLEN'(csr_idx), 0);
        check({tag, ".csr_wdata"},      csr_wdata, 0);
        check({tag, ".stall"},          XLEN'(stall), 0);
        check({tag, ".flush"},          XLEN'(flush), 0);
        check({tag, ".redirect_valid"}, XLEN'(redirect_valid), 0);
        check({tag, ".redirect_pc"},    redirect_pc, 0);
        check({tag, ".trap_ack"},       XLEN'(trap_ack), 0);
    endtask

    logic [XLEN-1:0] vec_exp;

    initial begin
        rst            = 1'b1;
        trap_valid     = 1'b0;
        mret_valid     = 1'b0;
        trap_cause     = '0;
        trap_pc        = '0;
        pipe_csr_we    = 1'b1;
        pipe_csr_idx   = 12'h305;
        pipe_csr_wdata = 64'h55;
        csr_mtvec      = 64'h8000_1000;
        csr_mepc       = '0;
        csr_mstatus    = 64'h8;
        #2;
        check_all_zero("reset");
        tick; tick;
        rst         = 1'b0;
        pipe_csr_we = 1'b0;
        tick;

        // Ecall with a pipeline write attempted during W_MEPC
        trap_pc    = 64'h8000_0010;
        trap_cause = 64'd11;
        trap_valid = 1'b1;
        #1;
        check("ecall.idle_stall", XLEN'(stall), 0);
        tick;
        pipe_csr_we    = 1'b1;
        pipe_csr_idx   = 12'h305;
        pipe_csr_wdata = 64'h999;
        #1;
        check_csr("ecall.w_mepc", 1'b1, 12'h341, 64'h8000_0010, 1'b1);
        tick;
        pipe_csr_we = 1'b0;
        #1;
        check_csr("ecall.w_mcause", 1'b1, 12'h342, 64'd11, 1'b1);
        tick;
        check_csr("ecall.w_mstat", 1'b1, 12'h300, 64'h1880, 1'b1);
        tick;
        check_redir("ecall.redir", 64'h8000_1000);
        trap_valid = 1'b0;
        tick;
        check("ecall.after_redir", XLEN'(redirect_valid), 0);
        check("ecall.after_stall", XLEN'(stall), 0);

        // mret
        csr_mepc    = 64'h8000_0014;
        csr_mstatus = 64'h1880;
        mret_valid  = 1'b1;
        tick;
        check_csr("mret.ret_mstat", 1'b1, 12'h300, 64'h1888, 1'b1);
        tick;
        check_redir("mret.redir", 64'h8000_0014);
        mret_valid = 1'b0;
        tick;

        // IDLE pass-through of a pipeline write
        pipe_csr_we    = 1'b1;
        pipe_csr_idx   = 12'h305;
        pipe_csr_wdata = 64'h123;
        #1;
        check_csr("idle.pass", 1'b1, 12'h305, 64'h123, 1'b0);

        // Trap and mret together: trap wins, same-cycle pipe write still performed
        csr_mstatus = 64'h8;
        trap_pc     = 64'h8000_0020;
        trap_cause  = 64'd2;
        trap_valid  = 1'b1;
        mret_valid  = 1'b1;
        #1;
        check_csr("both.idle_pipe", 1'b1, 12'h305, 64'h123, 1'b0);
        tick;
        pipe_csr_we = 1'b0;
        #1;
        check_csr("both.w_mepc", 1'b1, 12'h341, 64'h8000_0020, 1'b1);
        tick;
        check_csr("both.w_mcause", 1'b1, 12'h342, 64'd2, 1'b1);
        tick;
        check_csr("both.w_mstat", 1'b1, 12'h300, 64'h1880, 1'b1);
        tick;
        check_redir("both.redir", 64'h8000_1000);
        trap_valid  = 1'b0;
        csr_mstatus = 64'h1880;
        tick;
        check("both.idle_ack", XLEN'(trap_ack), 0);
        check("both.idle_stall", XLEN'(stall), 0);
        tick;
        check_csr("both.ret_mstat", 1'b1, 12'h300, 64'h1888, 1'b1);
        tick;
        check_redir("both.ret_redir", 64'h8000_0014);
        mret_valid = 1'b0;
        tick;

        // Vectored interrupt target
        csr_mtvec   = 64'h8000_1001;
        csr_mstatus = 64'h0;
        trap_pc     = 64'h8000_0030;
        trap_cause  = 64'h8000_0000_0000_0007;
        trap_valid  = 1'b1;
        tick;
        check_csr("vec.w_mepc", 1'b1, 12'h341, 64'h8000_0030, 1'b1);
        tick;
        check_csr("vec.w_mcause", 1'b1, 12'h342, 64'h8000_0000_0000_0007, 1'b1);
        tick;
        check_csr("vec.w_mstat", 1'b1, 12'h300, 64'h1800, 1'b1);
        tick;
`ifdef TRAP_VECTORED_EN
        vec_exp = 64'h8000_101C;
`else
        vec_exp = 64'h8000_1000;
`endif
        check_redir("vec.redir", vec_exp);
        trap_valid = 1'b0;
        tick;

        // Reset in the middle of W_MCAUSE
        csr_mtvec  = 64'h8000_1000;
        trap_pc    = 64'h8000_0040;
        trap_cause = 64'd3;
        trap_valid = 1'b1;
        tick;
        trap_valid = 1'b0;
        tick;
        check_csr("rst_mid.w_mcause", 1'b1, 12'h342, 64'd3, 1'b1);
        pipe_csr_we    = 1'b1;
        pipe_csr_idx   = 12'h305;
        pipe_csr_wdata = 64'h77;
        rst            = 1'b1;
        #1;
        check_all_zero("rst_mid.asserted");
        tick;
        rst         = 1'b0;
        pipe_csr_we = 1'b0;
        #1;
        check("rst_mid.idle_stall", XLEN'(stall), 0);
        for (int i = 0; i < 4; i++) begin
            tick;
            check($sformatf("rst_mid.no_redir%0d", i), XLEN'(redirect_valid), 0);
            check($sformatf("rst_mid.no_we%0d", i), XLEN'(csr_we), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
- Multi-cycle sequencer for machine-mode trap entry (ecall, illegal instruction, timer interrupt) and mret return.
- Owns the single CSR write port. Arbitrates it between pipeline CSR instructions and its own mepc/mcause/mstatus update sequence.
- Issues the PC redirect and pipeline stall/flush.
- Sits between the execute stage, csr_reg and the IF-stage PC mux.

Parameters:
XLEN, 64, data/PC width
CSR_AW, 12, CSR address width

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
trap_valid  in  1  execute stage requests trap entry; held until trap_ack
trap_cause  in  XLEN  mcause value (bit XLEN-1 = interrupt)
trap_pc  in  XLEN  PC of the trapping instruction
mret_valid  in  1  execute stage requests mret; held until trap_ack
trap_ack  out  1  one-cycle pulse when the redirect is issued
pipe_csr_we  in  1  pipeline CSR-instruction write
pipe_csr_idx  in  CSR_AW  pipeline CSR address
pipe_csr_wdata  in  XLEN  pipeline CSR write data
csr_mtvec  in  XLEN  current mtvec
csr_mepc  in  XLEN  current mepc
csr_mstatus  in  XLEN  current mstatus
csr_we  out  1  CSR write enable to csr_reg
csr_idx  out  CSR_AW  CSR write address
csr_wdata  out  XLEN  CSR write data
stall  out  1  freeze fetch..execute
flush  out  1  kill IF/ID/EX contents
redirect_valid  out  1  next-PC override valid
redirect_pc  out  XLEN  next-PC override value

Behaviour:
- States: IDLE, W_MEPC, W_MCAUSE, W_MSTAT, RET_MSTAT, REDIR.
- Reset (async, rst=1): state=IDLE. All outputs 0 (csr_we, csr_idx, csr_wdata, stall, flush, redirect_valid, redirect_pc, trap_ack).
- IDLE:
  - CSR write port passes through combinationally: csr_we=pipe_csr_we, csr_idx/csr_wdata from the pipeline.
  - trap_valid=1: capture trap_pc and trap_cause into internal regs, go to W_MEPC.
  - Else mret_valid=1: go to RET_MSTAT.
  - trap_valid and mret_valid both 1: trap wins; mret is not acknowledged.
  - A pipeline CSR write in the same cycle as the trap request is still performed in that cycle.
- Any non-IDLE state:
  - stall=1.
  - Pipeline writes are blocked (csr_we driven only by the FSM).
  - pipe_csr_we is ignored, not queued.
- W_MEPC: csr_we=1, idx=0x341, wdata=captured pc. Next state W_MCAUSE.
- W_MCAUSE: csr_we=1, idx=0x342, wdata=captured cause. Next state W_MSTAT.
- W_MSTAT:
  - csr_we=1, idx=0x300.
  - wdata = csr_mstatus with MPIE(bit7) set to MIE(bit3), MIE cleared, MPP[12:11] set to 2'b11. All other bits unchanged.
  - Next state REDIR with target = {csr_mtvec[XLEN-1:2],2'b00}.
- RET_MSTAT:
  - csr_we=1, idx=0x300.
  - wdata: MIE set to MPIE, MPIE set to 1, MPP set to 2'b11.
  - Target = csr_mepc. Next state REDIR.
- REDIR:
  - redirect_valid=1, flush=1, trap_ack=1, stall=0 for exactly one cycle.
  - redirect_pc = registered target.
  - Next state IDLE.
- Latency: trap entry = 4 cycles from accepted request to redirect pulse inclusive. mret = 2 cycles.
- The CSR values read in W_MSTAT/RET_MSTAT reflect all prior writes, because csr_reg writes on the edge.
- A new request is not sampled in REDIR. It is sampled earliest in the following IDLE cycle.
- Request inputs are don't-care while not in IDLE.
- Reset mid-sequence: immediate return to IDLE, outputs 0, partial CSR updates are not rolled back.
- Widths:
  - MPP is written only when XLEN>=13.
  - The target addition in the optional feature wraps modulo 2^XLEN.

Optional Feature:
- Macro: TRAP_VECTORED_EN.
- Defined: when csr_mtvec[1:0]==2'b01 and captured cause bit XLEN-1 is 1, target = base + 4*cause[XLEN-2:0]. Otherwise target = base.
- Undefined: target is always base. mtvec[1:0] is ignored.

Decomposition:
- Shared package (defines.v additions):
  - CSR addresses CSR_MSTATUS=0x300, CSR_MTVEC=0x305, CSR_MEPC=0x341, CSR_MCAUSE=0x342.
  - mstatus bit positions MIE=3, MPIE=7, MPP=12:11.
  - FSM state encodings.
- Natural sub-module: trap_mstatus_upd. Combinational next-mstatus for entry/return, selected by one mode bit. Shared by W_MSTAT and RET_MSTAT.

Test Plan:
- Reset mid-W_MCAUSE: assert rst -> all outputs 0 the same cycle; state IDLE; no redirect follows.
- Ecall: trap_pc=0x80000010, cause=11, mtvec=0x80001000, mstatus=0x8 ->
  - csr writes 0x341=0x80000010, 0x342=11, 0x300=0x1880 on consecutive cycles.
  - Then redirect_pc=0x80001000 with trap_ack=1.
  - stall=1 for 3 cycles.
- mret: mepc=0x80000014, mstatus=0x1880 -> write 0x300=0x1888; next cycle redirect_pc=0x80000014.
- Contention: pipe_csr_we=1 (idx 0x305) during W_MEPC -> csr_idx=0x341, pipeline write dropped. In IDLE, pipe write to 0x305=0x123 passes unchanged.
- Simultaneous trap_valid and mret_valid -> trap sequence runs, mepc written; mret serviced only after the next IDLE.
- TRAP_VECTORED_EN: mtvec=0x80001001, cause=0x8000000000000007 -> redirect_pc=0x8000101C. Without the macro -> 0x80001000.
